// File: rtl/img_proc_pkg.sv
// Shared widths and state type for the pixel-stream image processing blocks.
package img_proc_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned CNT_W   = 20;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_LATCH = 2'd2
    } bbox_state_t;

endpackage

// File: rtl/run_filter.sv
// Horizontal run-length qualifier: a white pixel qualifies once it completes
// a run of at least MIN_RUN consecutive white data-enable pixels.
module run_filter
    import img_proc_pkg::*;
#(
    parameter int unsigned MIN_RUN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic de,
    input  logic monoc,
    output logic qualified,
    output logic run_start
);

    localparam int unsigned RW = $clog2(MIN_RUN + 1);
    localparam logic [RW-1:0] RUN_SAT = RW'(MIN_RUN);
    localparam logic [RW:0]   RUN_REQ = (RW + 1)'(MIN_RUN);

    logic [RW-1:0] run_cnt;
    logic [RW:0]   run_incl;
    logic          white;

    assign white    = de & monoc;
    // Run length including the pixel currently presented.
    assign run_incl = {1'b0, run_cnt} + (RW + 1)'(1);

    assign qualified = white & (run_incl >= RUN_REQ);
    assign run_start = white & (run_incl == RUN_REQ);

    always_ff @(posedge clk) begin
        if (rst || !white) begin
            run_cnt <= '0;
        end else if (run_cnt != RUN_SAT) begin
            run_cnt <= run_cnt + RW'(1);
        end
    end

endmodule

// File: rtl/bbox_detect.sv
// Bounding box of qualified white runs in a binarized video stream, reported
// once per frame on the vsync rising edge; video is passed through one cycle late.
module bbox_detect
    import img_proc_pkg::*;
#(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned MIN_RUN = 3,
    parameter int unsigned MIN_PIX = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pre_frame_vsync,
    input  logic               pre_frame_hsync,
    input  logic               pre_frame_de,
    input  logic               monoc,
    output logic               post_frame_vsync,
    output logic               post_frame_hsync,
    output logic               post_frame_de,
    output logic               post_monoc,
    output logic [COORD_W-1:0] box_left,
    output logic [COORD_W-1:0] box_right,
    output logic [COORD_W-1:0] box_top,
    output logic [COORD_W-1:0] box_bottom,
    output logic               box_valid,
    output logic               box_update,
    output logic [CNT_W-1:0]   pix_cnt
);

    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] LEFT_BACK  = COORD_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0]   PIX_THRESH = CNT_W'(MIN_PIX);

    bbox_state_t state, state_next;

    logic               vsync_d;
    logic               de_d;
    logic               vs_rise;
    logic               de_fall;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] left_cand;
    logic               qualified;
    logic               run_start;
    logic               acc_en;
    logic               acc_clr;
    logic               do_latch;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
    logic [CNT_W-1:0]   cnt;

    assign vs_rise = pre_frame_vsync & ~vsync_d;
    assign de_fall = de_d & ~pre_frame_de;

    // The first qualified pixel of a run stands for the whole run behind it.
    assign left_cand = run_start ? (x_cnt - LEFT_BACK) : x_cnt;

    run_filter #(
        .MIN_RUN (MIN_RUN)
    ) u_run_filter (
        .clk       (clk),
        .rst       (rst),
        .de        (pre_frame_de),
        .monoc     (monoc),
        .qualified (qualified),
        .run_start (run_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d          <= 1'b0;
            de_d             <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            post_monoc       <= 1'b0;
        end else begin
            vsync_d          <= pre_frame_vsync;
            de_d             <= pre_frame_de;
            post_frame_vsync <= pre_frame_vsync;
            post_frame_hsync <= pre_frame_hsync;
            post_frame_de    <= pre_frame_de;
            post_monoc       <= monoc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
        end else if (pre_frame_de) begin
            if (x_cnt != X_MAX) begin
                x_cnt <= x_cnt + COORD_W'(1);
            end
        end else if (de_fall) begin
            x_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || vs_rise) begin
            y_cnt <= '0;
        end else if (de_fall && (y_cnt != Y_MAX)) begin
            y_cnt <= y_cnt + COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A vsync rise in SCAN closes the frame, so that cycle's pixel is dropped.
    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        do_latch   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vs_rise) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (vs_rise) begin
                    state_next = ST_LATCH;
                end else begin
                    acc_en = qualified;
                end
            end
            ST_LATCH: begin
                do_latch   = 1'b1;
                acc_clr    = 1'b1;
                state_next = ST_SCAN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            min_x <= COORD_MAX;
            max_x <= '0;
            min_y <= COORD_MAX;
            max_y <= '0;
            cnt   <= '0;
        end else if (acc_en) begin
            if (left_cand < min_x) begin
                min_x <= left_cand;
            end
            if (x_cnt > max_x) begin
                max_x <= x_cnt;
            end
            if (y_cnt < min_y) begin
                min_y <= y_cnt;
            end
            if (y_cnt > max_y) begin
                max_y <= y_cnt;
            end
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            box_valid  <= 1'b0;
            box_update <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            box_update <= do_latch;
            if (do_latch) begin
                pix_cnt <= cnt;
                if (cnt >= PIX_THRESH) begin
                    box_left   <= min_x;
                    box_right  <= max_x;
                    box_top    <= min_y;
                    box_bottom <= max_y;
                    box_valid  <= 1'b1;
                end else begin
                    box_left   <= '0;
                    box_right  <= '0;
                    box_top    <= '0;
                    box_bottom <= '0;
                    box_valid  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_detect.sv
// Self-checking bench for bbox_detect: directed and random frames scored
// against an image-level reference model of the qualification and box rules.
module tb_bbox_detect;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int MR = 2;
    localparam int MP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic        monoc;
    logic        post_vsync;
    logic        post_hsync;
    logic        post_de;
    logic        post_mono;
    logic [10:0] box_left;
    logic [10:0] box_right;
    logic [10:0] box_top;
    logic [10:0] box_bottom;
    logic        box_valid;
    logic        box_update;
    logic [19:0] pix_cnt;

    int          n_cmp;
    int          n_bad;
    bit          img [H][W];
    bit          cut;
    bit          armed;
    bit          vs_prev;
    int          due;
    logic [44:0] res_box;
    logic [44:0] held_box;
    logic [19:0] res_pix;
    logic [19:0] held_pix;

    always #5 clk = ~clk;

    bbox_detect #(
        .IMG_W   (W),
        .IMG_H   (H),
        .MIN_RUN (MR),
        .MIN_PIX (MP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (vsync),
        .pre_frame_hsync  (hsync),
        .pre_frame_de     (de),
        .monoc            (monoc),
        .post_frame_vsync (post_vsync),
        .post_frame_hsync (post_hsync),
        .post_frame_de    (post_de),
        .post_monoc       (post_mono),
        .box_left         (box_left),
        .box_right        (box_right),
        .box_top          (box_top),
        .box_bottom       (box_bottom),
        .box_valid        (box_valid),
        .box_update       (box_update),
        .pix_cnt          (pix_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A pixel counts when it ends a horizontal white run of MR pixels; the
    // box left edge reaches back to the start of that run.
    task automatic eval_frame();
        int c;
        int mnx;
        int mxx;
        int mny;
        int mxy;
        bit ok;
        c = 0; mnx = 2047; mxx = 0; mny = 2047; mxy = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = MR - 1; x < W; x++) begin
                ok = img[y][x];
                for (int k = 1; k < MR; k++) begin
                    if (!img[y][x-k]) ok = 1'b0;
                end
                if (cut && y == H - 1 && x == W - 1) ok = 1'b0;
                if (ok) begin
                    c++;
                    if (x - (MR - 1) < mnx) mnx = x - (MR - 1);
                    if (x > mxx) mxx = x;
                    if (y < mny) mny = y;
                    if (y > mxy) mxy = y;
                end
            end
        end
        res_pix = 20'(c);
        if (c >= MP) res_box = {11'(mnx), 11'(mxx), 11'(mny), 11'(mxy), 1'b1};
        else         res_box = '0;
    endtask

    task automatic tick();
        logic [3:0] drv;
        logic [3:0] post_exp;
        bit         upd_exp;
        drv      = {vsync, hsync, de, monoc};
        post_exp = rst ? 4'b0 : drv;
        if (rst) begin
            armed    = 1'b0;
            due      = -1;
            held_box = '0;
            held_pix = '0;
            vs_prev  = 1'b0;
        end else begin
            if (vsync && !vs_prev) begin
                if (armed) begin
                    eval_frame();
                    due = 2;
                end
                armed = 1'b1;
            end
            vs_prev = vsync;
        end
        @(posedge clk);
        #1;
        upd_exp = 1'b0;
        if (due > 0) begin
            due--;
            if (due == 0) begin
                upd_exp  = 1'b1;
                held_box = res_box;
                held_pix = res_pix;
                due      = -1;
            end
        end
        chk("post", 64'({post_vsync, post_hsync, post_de, post_mono}), 64'(post_exp));
        chk("update", 64'(box_update), 64'(upd_exp));
        chk("box", 64'({box_left, box_right, box_top, box_bottom, box_valid}), 64'(held_box));
        chk("pix_cnt", 64'(pix_cnt), 64'(held_pix));
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 1'b0;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                img[y][x] = 1'b1;
    endtask

    task automatic fill_random(input int pct);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic send_lines(input int y0, input int y1, input bit cut_last);
        for (int y = y0; y <= y1; y++) begin
            hsync = 1'b1; de = 1'b0; monoc = 1'b0; tick();
            hsync = 1'b0; tick();
            for (int x = 0; x < W; x++) begin
                if (cut_last && y == H - 1 && x == W - 1) return;
                de = 1'b1; monoc = img[y][x]; tick();
            end
            de = 1'b0; monoc = 1'b0; tick();
        end
        tick();
    endtask

    task automatic close_frame(input bit with_pix);
        cut   = with_pix;
        vsync = 1'b1;
        hsync = 1'b0;
        if (with_pix) begin
            de = 1'b1; monoc = img[H-1][W-1];
        end else begin
            de = 1'b0; monoc = 1'b0;
        end
        tick();
        de = 1'b0; monoc = 1'b0;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
        cut = 1'b0;
    endtask

    task automatic full_frame();
        send_lines(0, H - 1, 1'b0);
        close_frame(1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        cut = 1'b0; armed = 1'b0; vs_prev = 1'b0; due = -1;
        res_box = '0; held_box = '0; res_pix = '0; held_pix = '0;
        clear_img();

        rst = 1'b1; vsync = 1'b1; hsync = 1'b1; de = 1'b1; monoc = 1'b1;
        tick();
        vsync = 1'b0; hsync = 1'b0; de = 1'b0; monoc = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        close_frame(1'b0);

        clear_img(); set_rect(4, 7, 2, 4);
        full_frame();
        full_frame();

        clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ((x + y) % 2 == 0);
        full_frame();

        clear_img(); set_rect(10, 11, 1, 1); set_rect(10, 11, 6, 6);
        full_frame();
        clear_img(); set_rect(10, 11, 1, 1);
        full_frame();
        clear_img(); set_rect(9, 11, 1, 2); set_rect(10, 11, 5, 6);
        full_frame();

        clear_img(); set_rect(0, W - 1, 0, H - 1);
        full_frame();

        for (int i = 0; i < 5; i++) begin
            fill_random(15 + 20 * i);
            full_frame();
        end

        fill_random(80);
        img[H-1][W-2] = 1'b1;
        img[H-1][W-1] = 1'b1;
        send_lines(0, H - 1, 1'b1);
        close_frame(1'b1);

        fill_random(60);
        send_lines(0, 2, 1'b0);
        rst = 1'b1; de = 1'b1; monoc = 1'b1;
        tick();
        rst = 1'b0; de = 1'b0; monoc = 1'b0;
        send_lines(3, H - 1, 1'b0);
        close_frame(1'b0);
        clear_img(); set_rect(2, 12, 3, 5);
        full_frame();

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
